// File: rtl/ram8_arb_pkg.sv
// Shared types and sizes for the RAM8 two-requester arbiter.
// Word width, address width and the issue-stage record live here.
package ram8_arb_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef enum logic {ST_INIT, ST_RUN} state_e;
    typedef enum logic {REQ_A, REQ_B} req_id_e;

    typedef struct packed {
        logic               valid;
        req_id_e            id;
        logic               write;
        logic [ADDR_W-1:0]  addr;
        logic [DATA_W-1:0]  wdata;
    } issue_s;

endpackage

// File: rtl/ram8_arbiter_if.sv
// One requester port of the RAM8 arbiter: request handshake plus read response.
// master = client side, slave = arbiter side.
interface ram8_arbiter_if;
    import ram8_arb_pkg::*;

    logic               valid;
    logic               ready;
    logic               write;
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  wdata;
    logic               rvalid;
    logic [DATA_W-1:0]  rdata;

    modport master (output valid, write, addr, wdata, input ready, rvalid, rdata);
    modport slave  (input valid, write, addr, wdata, output ready, rvalid, rdata);
endinterface

// File: rtl/ram8_rr_arb2.sv
// Two-way round-robin picker; grant bit 0 = A, bit 1 = B.
// last_grant only moves on a grant, which is always a handshake.
module ram8_rr_arb2
    import ram8_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    req_id_e last_grant_q;

    always_comb begin
        grant = 2'b00;
        if (en) begin
            case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = (last_grant_q == REQ_B) ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    // Reset to B so that A wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_grant_q <= REQ_B;
        else if (grant[0])
            last_grant_q <= REQ_A;
        else if (grant[1])
            last_grant_q <= REQ_B;
    end

endmodule

// File: rtl/ram8_arbiter.sv
// Round-robin front end for one external RAM8: registered issue stage and read response.
// Optional RAM8_ARB_CLEAR_EN adds a post-reset zero-fill sweep of all 8 words.
//
// state   | meaning
// ST_INIT | clear sweep writing 0 to addresses 0..7, requests held off
// ST_RUN  | normal arbitration and issue
module ram8_arbiter
    import ram8_arb_pkg::*;
(
    input  logic                CLK,
    input  logic                RESET_N,
    ram8_arbiter_if.slave       a,
    ram8_arbiter_if.slave       b,
    output logic [DATA_W-1:0]   ram_in,
    output logic                ram_write_enable,
    output logic [ADDR_W-1:0]   ram_address,
    input  logic [DATA_W-1:0]   ram_out,
    output logic                busy
);

`ifdef RAM8_ARB_CLEAR_EN
    localparam state_e ST_RESET = ST_INIT;
    logic [ADDR_W-1:0] clr_addr_q;
`else
    localparam state_e ST_RESET = ST_RUN;
`endif

    state_e state_q, state_d;
    issue_s s1_q, s1_d;
    logic [1:0] grant;
    logic arb_en;
    logic a_rvalid_q, b_rvalid_q;
    logic [DATA_W-1:0] a_rdata_q, b_rdata_q;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            state_q <= ST_RESET;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
`ifdef RAM8_ARB_CLEAR_EN
            ST_INIT: if (clr_addr_q == ADDR_W'(DEPTH - 1)) state_d = ST_RUN;
`else
            ST_INIT: state_d = ST_RUN;
`endif
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_RESET;
        endcase
    end

`ifdef RAM8_ARB_CLEAR_EN
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            clr_addr_q <= '0;
        else if (state_q == ST_INIT)
            clr_addr_q <= clr_addr_q + 1'b1;
    end

    assign busy = (state_q == ST_INIT);
`else
    assign busy = 1'b0;
`endif

    // Ready is gated by reset too, since the state register alone would allow it mid-reset.
    assign arb_en = RESET_N && (state_q == ST_RUN);

    ram8_rr_arb2 u_arb (
        .clk   (CLK),
        .rst_n (RESET_N),
        .en    (arb_en),
        .req   ({b.valid, a.valid}),
        .grant (grant)
    );

    assign a.ready = grant[0];
    assign b.ready = grant[1];

    // Address/data hold their last value while the stage is idle.
    always_comb begin
        s1_d       = s1_q;
        s1_d.valid = 1'b0;
`ifdef RAM8_ARB_CLEAR_EN
        if (state_q == ST_INIT) begin
            s1_d.valid = 1'b1;
            s1_d.id    = REQ_A;
            s1_d.write = 1'b1;
            s1_d.addr  = clr_addr_q;
            s1_d.wdata = '0;
        end
`endif
        if (grant[0]) begin
            s1_d.valid = 1'b1;
            s1_d.id    = REQ_A;
            s1_d.write = a.write;
            s1_d.addr  = a.addr;
            s1_d.wdata = a.wdata;
        end else if (grant[1]) begin
            s1_d.valid = 1'b1;
            s1_d.id    = REQ_B;
            s1_d.write = b.write;
            s1_d.addr  = b.addr;
            s1_d.wdata = b.wdata;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            s1_q <= '0;
        else
            s1_q <= s1_d;
    end

    assign ram_address      = s1_q.addr;
    assign ram_in           = s1_q.wdata;
    assign ram_write_enable = s1_q.valid & s1_q.write;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            if (s1_q.valid && !s1_q.write) begin
                if (s1_q.id == REQ_A) begin
                    a_rvalid_q <= 1'b1;
                    a_rdata_q  <= ram_out;
                end else begin
                    b_rvalid_q <= 1'b1;
                    b_rdata_q  <= ram_out;
                end
            end
        end
    end

    assign a.rvalid = a_rvalid_q;
    assign a.rdata  = a_rdata_q;
    assign b.rvalid = b_rvalid_q;
    assign b.rdata  = b_rdata_q;

endmodule

// File: tb/tb_ram8_arbiter.sv
// Directed bench for ram8_arbiter with a behavioural RAM8 model.
// Honors RAM8_ARB_CLEAR_EN for the post-reset sweep expectations.
module tb_ram8_arbiter;
    import ram8_arb_pkg::*;

    logic CLK = 1'b0;
    logic RESET_N;
    logic [DATA_W-1:0] ram_in, ram_out;
    logic ram_write_enable;
    logic [ADDR_W-1:0] ram_address;
    logic busy;

    ram8_arbiter_if a_if ();
    ram8_arbiter_if b_if ();

    ram8_arbiter dut (
        .CLK              (CLK),
        .RESET_N          (RESET_N),
        .a                (a_if),
        .b                (b_if),
        .ram_in           (ram_in),
        .ram_write_enable (ram_write_enable),
        .ram_address      (ram_address),
        .ram_out          (ram_out),
        .busy             (busy)
    );

    always #5 CLK = ~CLK;

    logic [DATA_W-1:0] mem [DEPTH];
    always @(posedge CLK) if (ram_write_enable) mem[ram_address] <= ram_in;
    assign ram_out = mem[ram_address];

    int n_assert = 0;
    int n_fail   = 0;
    logic [DATA_W-1:0] exp_mem [DEPTH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [6:0] pat_a;
        logic [ADDR_W-1:0] ai, bi, ea;
        logic [DATA_W-1:0] ed, exp5;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = '0;
            exp_mem[i] = '0;
        end
        RESET_N = 1'b0;
        a_if.valid = 1'b1; a_if.write = 1'b0; a_if.addr = '0; a_if.wdata = '0;
        b_if.valid = 1'b1; b_if.write = 1'b0; b_if.addr = '0; b_if.wdata = '0;
        #12;
        chk("rst_a_ready", a_if.ready, 0);
        chk("rst_b_ready", b_if.ready, 0);
        chk("rst_we", ram_write_enable, 0);
        chk("rst_addr", ram_address, 0);
        chk("rst_ram_in", ram_in, 0);
        chk("rst_a_rvalid", a_if.rvalid, 0);
        chk("rst_b_rvalid", b_if.rvalid, 0);
        chk("rst_a_rdata", a_if.rdata, 0);
        chk("rst_b_rdata", b_if.rdata, 0);
`ifdef RAM8_ARB_CLEAR_EN
        chk("rst_busy", busy, 1);
`else
        chk("rst_busy", busy, 0);
`endif
        a_if.valid = 1'b0; b_if.valid = 1'b0;
        tick();
        RESET_N = 1'b1;

`ifdef RAM8_ARB_CLEAR_EN
        a_if.valid = 1'b1;
        #1;
        chk("init_busy", busy, 1);
        chk("init_ready", a_if.ready, 0);
        a_if.valid = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            tick();
            chk("sweep_we", ram_write_enable, 1);
            chk("sweep_addr", ram_address, k);
            chk("sweep_data", ram_in, 0);
            chk("sweep_busy", busy, (k < DEPTH - 1) ? 1 : 0);
        end
`endif

        // Contention: A writes 1..4, B writes 5..7, expected grant order A,B,A,B,A,B,A
        pat_a = 7'b1010101;
        ai = 3'd1; bi = 3'd5;
        for (int c = 0; c < 7; c++) begin
            a_if.valid = (ai >= 3'd1 && ai <= 3'd4); a_if.write = 1'b1;
            a_if.addr = ai; a_if.wdata = 16'h1100 + 16'(ai);
            b_if.valid = (bi >= 3'd5); b_if.write = 1'b1;
            b_if.addr = bi; b_if.wdata = 16'h2200 + 16'(bi);
            #1;
            chk("cont_a_ready", a_if.ready, pat_a[c]);
            chk("cont_b_ready", b_if.ready, !pat_a[c]);
            if (pat_a[c]) begin
                ea = ai; ed = 16'h1100 + 16'(ai); ai = ai + 3'd1;
                if (ai == 3'd5) ai = 3'd0;
            end else begin
                ea = bi; ed = 16'h2200 + 16'(bi); bi = bi + 3'd1;
            end
            exp_mem[ea] = ed;
            tick();
            chk("cont_we", ram_write_enable, 1);
            chk("cont_addr", ram_address, ea);
            chk("cont_data", ram_in, ed);
        end
        a_if.valid = 1'b0; b_if.valid = 1'b0;

        // A writes 0xAAAA to addr 0 then reads it back
        a_if.valid = 1'b1; a_if.write = 1'b1; a_if.addr = 3'd0; a_if.wdata = 16'hAAAA;
        #1;
        chk("wr0_ready", a_if.ready, 1);
        exp_mem[0] = 16'hAAAA;
        tick();
        chk("wr0_we", ram_write_enable, 1);
        chk("wr0_addr", ram_address, 0);
        chk("wr0_data", ram_in, 16'hAAAA);
        a_if.write = 1'b0;
        #1;
        chk("rd0_ready", a_if.ready, 1);
        tick();
        a_if.valid = 1'b0;
        chk("rd0_we", ram_write_enable, 0);
        chk("rd0_rvalid_early", a_if.rvalid, 0);
        tick();
        chk("rd0_rvalid", a_if.rvalid, 1);
        chk("rd0_rdata", a_if.rdata, 16'hAAAA);
        tick();
        chk("rd0_rvalid_pulse", a_if.rvalid, 0);
        chk("rd0_rdata_hold", a_if.rdata, 16'hAAAA);

        // Back-to-back read-back of all 8 words
        for (int i = 0; i <= DEPTH; i++) begin
            a_if.valid = (i < DEPTH); a_if.write = 1'b0; a_if.addr = ADDR_W'(i);
            #1;
            if (i < DEPTH) chk("rb_ready", a_if.ready, 1);
            tick();
            if (i >= 1) begin
                chk("rb_rvalid", a_if.rvalid, 1);
                chk("rb_rdata", a_if.rdata, exp_mem[i-1]);
            end
        end
        a_if.valid = 1'b0;

        // A writes 0x1234 to addr 6, B reads addr 6 the next cycle
        a_if.valid = 1'b1; a_if.write = 1'b1; a_if.addr = 3'd6; a_if.wdata = 16'h1234;
        #1;
        chk("fw_a_ready", a_if.ready, 1);
        tick();
        a_if.valid = 1'b0;
        b_if.valid = 1'b1; b_if.write = 1'b0; b_if.addr = 3'd6;
        #1;
        chk("fw_b_ready", b_if.ready, 1);
        tick();
        b_if.valid = 1'b0;
        tick();
        chk("fw_b_rvalid", b_if.rvalid, 1);
        chk("fw_b_rdata", b_if.rdata, 16'h1234);
        chk("fw_a_rvalid", a_if.rvalid, 0);

        // Same address from A and B together: A first, B last, B's data remains
        a_if.valid = 1'b1; a_if.write = 1'b1; a_if.addr = 3'd2; a_if.wdata = 16'hA2A2;
        b_if.valid = 1'b1; b_if.write = 1'b1; b_if.addr = 3'd2; b_if.wdata = 16'hB2B2;
        #1;
        chk("same_a_ready", a_if.ready, 1);
        chk("same_b_ready", b_if.ready, 0);
        tick();
        a_if.valid = 1'b0;
        #1;
        chk("same_b_ready2", b_if.ready, 1);
        tick();
        b_if.valid = 1'b0;
        chk("same_b_data", ram_in, 16'hB2B2);
        a_if.valid = 1'b1; a_if.write = 1'b0; a_if.addr = 3'd2;
        #1;
        tick();
        a_if.valid = 1'b0;
        tick();
        chk("same_rvalid", a_if.rvalid, 1);
        chk("same_rdata", a_if.rdata, 16'hB2B2);

        // Reset while a write of 0xFFFF to addr 5 sits in stage 1
        a_if.valid = 1'b1; a_if.write = 1'b1; a_if.addr = 3'd5; a_if.wdata = 16'hFFFF;
        #1;
        tick();
        a_if.valid = 1'b0;
        chk("mid_we_before", ram_write_enable, 1);
        chk("mid_data_before", ram_in, 16'hFFFF);
        #2;
        RESET_N = 1'b0;
        #1;
        chk("mid_we_drop", ram_write_enable, 0);
        chk("mid_addr", ram_address, 0);
        chk("mid_rdata_clr", a_if.rdata, 0);
        tick();
        chk("mid_a_rvalid", a_if.rvalid, 0);
        chk("mid_b_rvalid", b_if.rvalid, 0);
        RESET_N = 1'b1;
`ifdef RAM8_ARB_CLEAR_EN
        repeat (DEPTH) tick();
        exp5 = 16'h0000;
`else
        exp5 = 16'h2205;
`endif
        a_if.valid = 1'b1; a_if.write = 1'b0; a_if.addr = 3'd5;
        #1;
        chk("post_ready", a_if.ready, 1);
        tick();
        a_if.valid = 1'b0;
        tick();
        chk("post_rvalid", a_if.rvalid, 1);
        chk("post_rdata", a_if.rdata, exp5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ram8_arbiter.md
# ram8_arbiter

Two-requester controller sharing one RAM8 (8 x 16-bit, synchronous write on CLK rising edge, combinational read of `address`). Arbitrates requesters A and B round-robin with valid/ready handshakes, registers every RAM drive, and returns read data through a registered response. Sits between two datapath clients and the external RAM8 instance.

## Interface
- DATA_W, 16, word width; must match RAM8 `in`/`out`
- ADDR_W, 3, address width; depth = 2**ADDR_W = 8
- CLK  in  1  system clock, all state on rising edge
- RESET_N  in  1  asynchronous, active-low reset
- a_valid / b_valid  in  1  request present
- a_ready / b_ready  out  1  request accepted this cycle (valid & ready = handshake)
- a_write / b_write  in  1  1 = write, 0 = read
- a_addr / b_addr  in  ADDR_W  word address
- a_wdata / b_wdata  in  DATA_W  write data
- a_rvalid / b_rvalid  out  1  one-cycle pulse, read data valid
- a_rdata / b_rdata  out  DATA_W  read data, held until next response to same port
- ram_in  out  DATA_W  to RAM8 `in`
- ram_write_enable  out  1  to RAM8 `write_enable`
- ram_address  out  ADDR_W  to RAM8 `address`
- ram_out  in  DATA_W  from RAM8 `out`
- busy  out  1  clear sweep in progress (0 when clear compiled out)

## Operation
- States: ST_INIT (clear sweep, only with macro), ST_RUN. Reset enters ST_INIT if compiled in, else ST_RUN.
- In ST_RUN: grant at most one requester per cycle. Only one valid -> that one wins. Both valid -> the one not granted last wins. `last_grant` resets to B, so A wins the first contention. `last_grant` updates only on handshake.
- Ready is combinational from valid and `last_grant`; loser's ready = 0; ready = 0 in ST_INIT and during reset.
- Stage 1 (issue register): accepted request latched (valid, id, write, addr, wdata). Stage 1 drives ram_address/ram_in/ram_write_enable directly from registers; ram_write_enable = stage1.valid & stage1.write.
- Stage 2 (response): for a stage-1 read, ram_out captured into the requester's rdata register; rvalid pulses for exactly one cycle on that port. Writes produce no response.
- Idle stage 1: ram_write_enable = 0; address/data hold last value.
- Ordering: strictly in acceptance order; write accepted cycle N is visible to read accepted N+1 or later.
- Same address, back-to-back writes from A then B: last accepted wins.
- Async reset mid-transaction: stage 1/2 cleared immediately, in-flight write not performed, no rvalid; rdata registers -> 0.

## Timing
- Reset values: all ready/rvalid 0, rdata 0, ram_write_enable 0, ram_address 0, ram_in 0, busy 1 (macro on) / 0 (off).
- Accept in cycle N -> RAM driven in N+1 -> write committed at end of N+1; read rvalid/rdata in N+2. Read latency 2.
- Throughput: one transaction per cycle sustained; alternates A/B under continuous contention.

## Configuration
- RAM8_ARB_CLEAR_EN defined: after RESET_N deasserts, ST_INIT issues 8 writes of 0 to addresses 0..7 over 8 consecutive cycles (ram_write_enable = 1), busy = 1, ready = 0; ST_RUN entered the cycle after address 7. Reset during sweep restarts at address 0.
- Not defined: no ST_INIT, busy tied 0, RAM contents after reset undefined; first handshake possible in first cycle after reset release.

## Structure
- Package ram8_arb_pkg: DATA_W, ADDR_W, DEPTH, state enum {ST_INIT, ST_RUN}, requester id enum {REQ_A, REQ_B}, issue-stage struct (valid, id, write, addr, wdata).
- Sub-module ram8_rr_arb2: two-way round-robin picker (valids + last_grant in, one-hot grant out, last_grant register inside).
- RAM8 instantiated outside; block only drives its ports.

## Test plan
- A writes 0xAAAA to addr 0, then reads addr 0 -> ram_write_enable high one cycle after accept; a_rvalid with a_rdata = 0xAAAA two cycles after read accept.
- A and B valid every cycle, A writes addr 1..4, B writes addr 5..7 -> grants alternate A,B,A,B…, A first; read-back of all 8 addresses returns written values.
- A writes 0x1234 to addr 6 in cycle N, B reads addr 6 in N+1 -> b_rdata = 0x1234.
- Macro on: after reset, busy high 8 cycles, ready low, addresses 0..7 written 0; reads of addr 3 return 0x0000.
- RESET_N asserted while a write of 0xFFFF to addr 5 sits in stage 1 -> ram_write_enable drops immediately, no rvalid; after recovery addr 5 does not hold 0xFFFF (0x0000 with macro on).
